rr_mux_stream: RTL
==================

# rr_mux_stream

Parametrised, registered N-bit, CHANNELS-to-1 stream multiplexer with valid/ready handshakes on every input and on the output. It has two selection modes: direct (an external `switch` picks the channel) and round-robin arbitration among valid channels. It replaces the purely combinational mux tree wherever several producers share one consumer and backpressure or fairness matters. A one-entry output register gives one-cycle latency and full throughput of one transfer per cycle.

## Interface
- `N`, 1: data width per channel, ≥1.
- `CHANNELS`, 16: number of input channels, ≥2 (need not be a power of two).
- `SEL_W`, $clog2(CHANNELS): select/channel-index width; derived, never overridden.

- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_data`  input  CHANNELS*N  flattened channel data; channel i occupies bits [i*N +: N].
- `in_valid`  input  CHANNELS  per-channel valid.
- `in_ready`  output  CHANNELS  per-channel ready (combinational).
- `mode`  input  1  0 = direct select, 1 = round-robin.
- `switch`  input  SEL_W  channel index used in direct mode; ignored in round-robin.
- `out_data`  output  N  registered data.
- `out_channel`  output  SEL_W  registered index of the channel that supplied `out_data`.
- `out_valid`  output  1  registered valid.
- `out_ready`  input  1  consumer ready.

## Operation
- `load_en = !out_valid || out_ready`. The output register accepts a new word only when `load_en` is high.
- Grant (combinational, at most one channel):
  - Direct mode: grant `switch` if `switch < CHANNELS` and `in_valid[switch]`; otherwise no grant. An out-of-range `switch` never grants and never asserts any `in_ready`.
  - Round-robin mode: grant the first valid channel found scanning `ptr+1, ptr+2, …`, wrapping modulo CHANNELS and ending at `ptr` itself. No valid channels means no grant.
- `in_ready[i] = load_en && grant_valid && grant == i`. All other `in_ready` bits are 0.
- An input transfer occurs on channel i when `in_valid[i] && in_ready[i]`. At the next edge: `out_data <= in_data[i*N +: N]`, `out_channel <= i`, `out_valid <= 1`.
- If `load_en` is high and there is no grant, then `out_valid <= 0` at the next edge.
- If `out_valid && !out_ready`, then `out_data`, `out_channel` and `out_valid` hold exactly.
- Round-robin pointer `ptr` (SEL_W bits):
  - Updates to the granted index on every input transfer, in either mode.
  - Is otherwise unchanged.
  - Wraps from CHANNELS-1 to 0 with no out-of-range values.
- `mode` and `switch` may change on any cycle. The change takes effect combinationally in that cycle, and `ptr` is retained across mode changes.
- Producers must hold data stable while valid and not ready. The block does not check this.

## Timing
- Reset (`rst` high at an edge):
  - `out_valid = 0`, `out_data = 0`, `out_channel = 0`.
  - `ptr = CHANNELS-1`, so channel 0 has first priority after reset.
  - Every `in_ready` reads 0 while `rst` is high.
- Reset mid-operation: a word held in the output register is discarded. No input transfer counts during a cycle in which `rst` is high.
- Latency: input transfer at edge k makes `out_valid` high for cycle k+1.
- Throughput: one word per cycle while `out_ready` stays high and a grant exists.
- Simultaneous output drain and refill: when `out_valid && out_ready` and a grant exists, the output register reloads in the same edge with no bubble.
- `out_ready` low with `out_valid` low does not stall loading (`load_en = 1`).
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode`, `switch` and `ptr`. There is no combinational path from `in_data` to any output.

## Test plan
- Reset behaviour: hold `rst` for 2 cycles with all inputs valid. Required: `out_valid = 0`, `out_data = 0`, `in_ready = 0` throughout; one cycle after release, `out_channel = 0`.
- Direct select (N=8, CHANNELS=16): `mode = 0`, `switch = 5`, `in_data[5] = 8'hA5`, all channels valid, `out_ready = 1`. Required: only `in_ready[5]` is high; next cycle `out_data = 8'hA5`, `out_channel = 5`. Repeat with `switch = 15`: `out_channel = 15`. CHANNELS=12 with `switch = 13`: no `in_ready`, `out_valid` drops to 0.
- Round-robin fairness: `mode = 1`, all 16 channels valid continuously, `out_ready = 1`. Required: `out_channel` sequence 0, 1, …, 15, 0, 1 on consecutive cycles with no bubbles.
- Sparse round-robin with wrap: only channels 3, 9 and 14 valid. Required: grants 3, 9, 14, 3 in order. Then drop channel 3 and add channel 1 after the grant to 14: next grant is 1.
- Backpressure: load `8'h3C` from channel 2, then hold `out_ready = 0` for 4 cycles with channel 7 valid. Required: `out_data = 8'h3C`, `out_channel = 2`, `out_valid = 1` stable; `in_ready = 0`. When `out_ready` rises, the same edge loads channel 7 with no bubble.
- Reset mid-stream: assert `rst` while `out_valid = 1` and `ptr = 6` in round-robin mode with all channels valid. Required: the cycle after reset release shows `out_valid = 0`; the first grant after release is channel 0.

Source files
------------

// File: rtl/rr_mux_stream_if.sv
// Handshake bundle for rr_mux_stream: per-channel input streams, mode/select
// controls and the single registered output stream.
interface rr_mux_stream_if #(
  parameter int N        = 1,
  parameter int CHANNELS = 16
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*N-1:0] in_data;
  logic [CHANNELS-1:0]   in_valid;
  logic [CHANNELS-1:0]   in_ready;
  logic                  mode;
  logic [SEL_W-1:0]      switch;
  logic [N-1:0]          out_data;
  logic [SEL_W-1:0]      out_channel;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, mode, switch, out_ready,
    output in_ready, out_data, out_channel, out_valid
  );

  modport master (
    output in_data, in_valid, mode, switch, out_ready,
    input  in_ready, out_data, out_channel, out_valid
  );
endinterface

// File: rtl/rr_mux_stream.sv
// Registered CHANNELS-to-1 stream mux with direct or round-robin selection
// and a one-entry output register (one-cycle latency, full throughput).
module rr_mux_stream #(
  parameter int N        = 1,
  parameter int CHANNELS = 16
) (
  input logic           clk,
  input logic           rst,
  rr_mux_stream_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                 load_en;
  logic                 grant_valid;
  logic [SEL_W-1:0]     grant;
  logic [SEL_W-1:0]     cand;
  logic [SEL_W-1:0]     ptr_p0;
  logic signed [N-1:0]  data_p0;
  logic [SEL_W-1:0]     chan_p0;
  logic                 vld_p0;

  assign load_en = !vld_p0 || bus.out_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    if (!bus.mode) begin
      if ({1'b0, bus.switch} < (SEL_W+1)'(CHANNELS) && bus.in_valid[bus.switch]) begin
        grant_valid = 1'b1;
        grant       = bus.switch;
      end
    end else begin
      // Scan starts just past the last winner so it drops to lowest priority.
      for (int k = 1; k <= CHANNELS; k++) begin
        cand = SEL_W'((int'(ptr_p0) + k) % CHANNELS);
        if (!grant_valid && bus.in_valid[cand]) begin
          grant_valid = 1'b1;
          grant       = cand;
        end
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (!rst && load_en && grant_valid)
      bus.in_ready[grant] = 1'b1;
  end

  // Stage p0: output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      chan_p0 <= '0;
      ptr_p0  <= SEL_W'(CHANNELS - 1);
    end else if (load_en) begin
      vld_p0 <= grant_valid;
      if (grant_valid) begin
        data_p0 <= bus.in_data[int'(grant)*N +: N];
        chan_p0 <= grant;
        ptr_p0  <= grant;
      end
    end
  end

  assign bus.out_data    = data_p0;
  assign bus.out_channel = chan_p0;
  assign bus.out_valid   = vld_p0;
endmodule
